mov_src_fifo: RTL and testbench
===============================

Name: mov_src_fifo

Overview:
- Operand buffer directly upstream of the 16-bit MOV register stage; decouples the operand producer (decode/register-read) from MOV timing.
- Queues up to DEPTH source words with a valid/ready input handshake.
- Pops one word per cycle into a registered src/mov_enable pair that drives the MOV stage's src and mov_enable inputs.

Parameters:
DATA_WIDTH, 16, width of each queued source word and of src
DEPTH, 4, number of storage entries (power of two)
ADDR_WIDTH, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-low reset
in_data  input  DATA_WIDTH  source word offered by producer
in_valid  input  1  producer has a word on in_data
in_ready  output  1  FIFO can accept a word this cycle
out_ready  input  1  consumer allows a pop this cycle
flush  input  1  synchronous clear of all queued words
src  output  DATA_WIDTH  registered word presented to MOV stage
mov_enable  output  1  registered one-cycle strobe; src valid for MOV capture on next edge
count  output  ADDR_WIDTH+1  number of words currently stored (0..DEPTH)
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, src=0, mov_enable=0, all storage entries=0; takes effect immediately, including mid-transfer. Queued words are lost.
- in_ready = !full (combinational from count); full and empty are combinational from count.
- Push: on a rising edge with in_valid && in_ready, write in_data to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- in_valid while full: ignored; no write, no pointer change, no error flag.
- Pop: on a rising edge with out_ready && !empty:
  - src <= mem[rd_ptr]; mov_enable <= 1; rd_ptr increments modulo DEPTH.
- No pop that edge: mov_enable <= 0; src holds its last value.
- Pop decision uses count before the edge. No bypass: a word pushed into an empty FIFO cannot pop on the same edge.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop on the same edge: unchanged; both pointers advance.
- Pointer wrap: DEPTH-1 -> 0 with no gap. Order is strictly FIFO across wrap.
- Flush, sampled on the rising edge, has priority over push and pop that edge:
  - wr_ptr, rd_ptr, count <= 0; mov_enable <= 0; src holds.
  - in_ready reads 1 in the following cycle.
- Latency:
  - Word accepted at edge N is at the head no earlier than edge N+1.
  - If it reaches the head with out_ready high at edge N+1, mov_enable and src are valid after N+1.
  - The MOV stage captures it into dest at edge N+2.
- Throughput: one word per cycle sustained when in_valid and out_ready are held high.
- mov_enable never stays high for two cycles unless two consecutive pops occur.

Test Plan:
- Reset then single word: rst low 2 cycles, then high; push 16'h000A; hold out_ready=1.
  -> count 1 after push edge; next edge src=16'h000A, mov_enable=1 for one cycle; count 0, empty=1.
- Fill and overflow: out_ready=0; push 16'h0001..16'h0005.
  -> first four accepted, full=1, in_ready=0, count=4; 16'h0005 dropped.
  -> then out_ready=1: src sequence 1,2,3,4 on consecutive cycles; mov_enable high 4 cycles; empty=1.
- Wrap and simultaneous push/pop: stream 10 words 16'hF000+i with in_valid=out_ready=1 continuously.
  -> count stays at 1 after the first edge; src emits F000..F009 in order across pointer wrap; no drops.
- Flush priority: 3 words queued; assert flush with in_valid=1 and out_ready=1 on the same edge.
  -> count=0, empty=1, mov_enable=0, src unchanged, pushed word not stored.
- Reset mid-operation: 2 words queued, mov_enable=1; drop rst asynchronously between edges.
  -> src=0, mov_enable=0, count=0 immediately, before the next edge.
- Chained with MOV stage: push 16'hF00C, out_ready=1.
  -> MOV dest reads 16'hF00C two edges after the push edge; dest holds while mov_enable=0 afterwards.

Source files
------------

// File: rtl/mov_src_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mov_src_fifo                                               |
// | Description : Operand buffer placed directly upstream of the 16-bit MOV  |
// |               register stage. It accepts source words from the operand   |
// |               producer (decode/register-read) using a valid/ready        |
// |               handshake. It pops at most one word per cycle into a       |
// |               registered src/mov_enable pair that drives the MOV stage.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1            rising-edge clock                         |
// |   rst        in   1            asynchronous reset, active low            |
// |   in_data    in   DATA_WIDTH   source word offered by the producer       |
// |   in_valid   in   1            producer has a word on in_data            |
// |   in_ready   out  1            FIFO can accept a word this cycle         |
// |   out_ready  in   1            consumer allows a pop this cycle          |
// |   flush      in   1            synchronous clear of all queued words     |
// |   src        out  DATA_WIDTH   registered word presented to MOV stage    |
// |   mov_enable out  1            one-cycle strobe qualifying src           |
// |   count      out  ADDR_WIDTH+1 number of stored words (0..DEPTH)         |
// |   full       out  1            count == DEPTH                            |
// |   empty      out  1            count == 0                                |
// +--------------------------------------------------------------------------+
module mov_src_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  out_ready,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] src,
   output logic                  mov_enable,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty
);

   // Occupancy constants sized to the count register.
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = (ADDR_WIDTH)'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q,  count_d;
   logic [DATA_WIDTH-1:0] src_q,    src_d;
   logic                  mov_en_q, mov_en_d;

   // ------------------------------------------------------------------
   // Status flags are decoded directly from the occupancy count.
   // ------------------------------------------------------------------
   logic full_w;
   logic empty_w;
   logic push_w;
   logic pop_w;

   assign full_w  = (count_q == CNT_FULL);
   assign empty_w = (count_q == CNT_ZERO);

   // Flush overrides both sides of the FIFO on the same edge. The pop
   // decision uses the count before the edge, so a word written on this
   // edge into an empty FIFO cannot leave on the same edge.
   assign push_w = in_valid  && !full_w  && !flush;
   assign pop_w  = out_ready && !empty_w && !flush;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      src_d    = src_q;
      mov_en_d = 1'b0;

      if (flush) begin
         // src deliberately holds its last value across a flush.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers are ADDR_WIDTH wide and DEPTH is a power of two, so
         // natural overflow gives the DEPTH-1 -> 0 wrap.
         if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            src_d    = mem_q[rd_ptr_q];
            mov_en_d = 1'b1;
         end
         case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         src_q    <= '0;
         mov_en_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         src_q    <= src_d;
         mov_en_q <= mov_en_d;
      end
   end

   // ------------------------------------------------------------------
   // Storage array, cleared by reset so that no stale operand can ever be
   // observed after a reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_w) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready   = !full_w;
   assign full       = full_w;
   assign empty      = empty_w;
   assign count      = count_q;
   assign src        = src_q;
   assign mov_enable = mov_en_q;

endmodule
`default_nettype wire

// File: tb/tb_mov_src_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mov_src_fifo                                            |
// | Description : Scoreboard testbench for mov_src_fifo. Stimulus pushes the |
// |               expected popped words into a queue; a monitor compares     |
// |               every mov_enable strobe against the queue head. A small    |
// |               downstream MOV register models the consuming stage.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mov_src_fifo;

   localparam int DW = 16;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          out_ready = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] src;
   logic          mov_enable;
   logic [AW:0]   count;
   logic          full;
   logic          empty;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] dest;

   always #5 clk = ~clk;

   mov_src_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_ready  (out_ready),
      .flush      (flush),
      .src        (src),
      .mov_enable (mov_enable),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   // Downstream MOV register stage.
   always @(posedge clk or negedge rst) begin
      if (!rst)            dest <= '0;
      else if (mov_enable) dest <= src;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every pop strobe must match the scoreboard head.
   always @(posedge clk) begin
      #1;
      if (rst && mov_enable) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pop: got src %h expected no pop", src);
         end else begin
            chk("pop_src", {16'h0, src}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // Push a word on the next edge; expect it to be popped if accepted.
   task automatic drive_push(input logic [DW-1:0] d, input bit accepted);
      in_data  = d;
      in_valid = 1'b1;
      if (accepted) exp_q.push_back(d);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- reset then single word ----------------
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_mov_en", 32'(mov_enable), 32'd0);
      chk("rst_src", 32'(src), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      drive_push(16'h000A, 1'b1);
      in_valid = 1'b0;
      chk("t1_count_after_push", 32'(count), 32'd1);
      chk("t1_no_bypass", 32'(mov_enable), 32'd0);
      @(negedge clk);
      chk("t1_mov_en", 32'(mov_enable), 32'd1);
      chk("t1_src", 32'(src), 32'h000A);
      chk("t1_count0", 32'(count), 32'd0);
      chk("t1_empty", 32'(empty), 32'd1);
      @(negedge clk);
      chk("t1_strobe_one_cycle", 32'(mov_enable), 32'd0);

      // ---------------- fill and overflow ----------------
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) drive_push(DW'(i), 1'b1);
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_in_ready", 32'(in_ready), 32'd0);
      chk("t2_count4", 32'(count), 32'd4);
      drive_push(16'h0005, 1'b0);
      in_valid = 1'b0;
      chk("t2_overflow_count", 32'(count), 32'd4);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("t2_drain_mov_en", 32'(mov_enable), 32'd1);
         chk("t2_drain_src", 32'(src), 32'(i));
      end
      chk("t2_empty", 32'(empty), 32'd1);
      @(negedge clk);
      chk("t2_no_word5", 32'(mov_enable), 32'd0);

      // ---------------- wrap with simultaneous push/pop ----------------
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_push(16'hF000 + DW'(i), 1'b1);
         chk("t3_count_steady", 32'(count), 32'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("t3_last_src", 32'(src), 32'hF009);
      chk("t3_count0", 32'(count), 32'd0);
      @(negedge clk);

      // ---------------- flush priority ----------------
      out_ready = 1'b0;
      drive_push(16'h0B01, 1'b1);
      drive_push(16'h0B02, 1'b1);
      drive_push(16'h0B03, 1'b1);
      chk("t4_count3", 32'(count), 32'd3);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hDEAD;
      out_ready = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      chk("t4_count0", 32'(count), 32'd0);
      chk("t4_empty", 32'(empty), 32'd1);
      chk("t4_mov_en", 32'(mov_enable), 32'd0);
      chk("t4_src_hold", 32'(src), 32'hF009);
      chk("t4_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      chk("t4_nothing_stored", 32'(count), 32'd0);

      // ---------------- reset mid-operation ----------------
      out_ready = 1'b0;
      drive_push(16'h0C01, 1'b1);
      drive_push(16'h0C02, 1'b1);
      drive_push(16'h0C03, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t5_pre_mov_en", 32'(mov_enable), 32'd1);
      chk("t5_pre_count", 32'(count), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      exp_q.delete();
      chk("t5_async_src", 32'(src), 32'd0);
      chk("t5_async_mov_en", 32'(mov_enable), 32'd0);
      chk("t5_async_count", 32'(count), 32'd0);
      chk("t5_async_empty", 32'(empty), 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // ---------------- chained with MOV stage ----------------
      out_ready = 1'b1;
      drive_push(16'hF00C, 1'b1);
      in_valid = 1'b0;
      chk("t6_dest_n", 32'(dest), 32'd0);
      @(negedge clk);
      chk("t6_dest_n1", 32'(dest), 32'd0);
      @(negedge clk);
      chk("t6_dest_n2", 32'(dest), 32'hF00C);
      @(negedge clk);
      chk("t6_dest_hold", 32'(dest), 32'hF00C);
      chk("t6_mov_en_low", 32'(mov_enable), 32'd0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
